// File: rtl/eightbit_alu_sequencer_pkg.sv
// Shared definitions for the ALU self-test sequencer: FSM states and the
// layout of one 29-bit test vector {s, a, b, exp_f, exp_ovf, exp_br}.
package eightbit_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

  localparam int S_W   = 3;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int F_W   = 8;
  localparam int OVF_W = 1;
  localparam int BR_W  = 1;
  localparam int VEC_W = S_W + A_W + B_W + F_W + OVF_W + BR_W;

  localparam int BR_LSB  = 0;
  localparam int OVF_LSB = BR_LSB + BR_W;
  localparam int F_LSB   = OVF_LSB + OVF_W;
  localparam int B_LSB   = F_LSB + F_W;
  localparam int A_LSB   = B_LSB + B_W;
  localparam int S_LSB   = A_LSB + A_W;

  typedef logic [VEC_W-1:0] vec_t;

  function automatic vec_t make_vec(input logic [S_W-1:0] s, input logic [A_W-1:0] a,
                                    input logic [B_W-1:0] b, input logic [F_W-1:0] f,
                                    input logic ovf, input logic br);
    return {s, a, b, f, ovf, br};
  endfunction

endpackage

// File: rtl/eightbit_alu_sequencer_if.sv
// Operand/result bus between the sequencer (master) and the eightbit_alu (slave).
interface eightbit_alu_sequencer_if;
  import eightbit_alu_sequencer_pkg::*;

  logic [S_W-1:0] alu_s;
  logic [A_W-1:0] alu_a;
  logic [B_W-1:0] alu_b;
  logic [F_W-1:0] alu_f;
  logic           alu_ovf;
  logic           alu_take_branch;

  modport master (output alu_s, alu_a, alu_b, input alu_f, alu_ovf, alu_take_branch);
  modport slave  (input alu_s, alu_a, alu_b, output alu_f, alu_ovf, alu_take_branch);
endinterface

// File: rtl/eightbit_alu_sequencer_rom.sv
// Fixed table of 16 ALU test vectors; combinational lookup by vector index.
module alu_vec_rom
  import eightbit_alu_sequencer_pkg::*;
(
  input  logic [3:0] addr,
  output vec_t       data
);

  // ops: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 shl, 7 shr; br means f==0
  always_comb begin
    data = '0;
    case (addr)
      4'd0:  data = make_vec(3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
      4'd1:  data = make_vec(3'd0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
      4'd2:  data = make_vec(3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
      4'd3:  data = make_vec(3'd1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
      4'd4:  data = make_vec(3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
      4'd5:  data = make_vec(3'd1, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1);
      4'd6:  data = make_vec(3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
      4'd7:  data = make_vec(3'd2, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1);
      4'd8:  data = make_vec(3'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0);
      4'd9:  data = make_vec(3'd3, 8'h12, 8'h24, 8'h36, 1'b0, 1'b0);
      4'd10: data = make_vec(3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
      4'd11: data = make_vec(3'd4, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1);
      4'd12: data = make_vec(3'd5, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
      4'd13: data = make_vec(3'd6, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
      4'd14: data = make_vec(3'd7, 8'h03, 8'h00, 8'h01, 1'b1, 1'b0);
      4'd15: data = make_vec(3'd6, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/eightbit_alu_sequencer.sv
// Self-test sequencer: drives ROM vectors into the ALU, waits to settle,
// compares results and reports error count and first failing index.
module eightbit_alu_sequencer
  import eightbit_alu_sequencer_pkg::*;
#(
  parameter int NUM_VEC       = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  eightbit_alu_sequencer_if.master        alu,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [4:0]                      err_count,
  output logic                            first_fail_valid,
  output logic [3:0]                      first_fail_idx,
  output logic [3:0]                      vec_idx
);

  localparam logic [3:0] LAST_IDX    = 4'(NUM_VEC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  seq_state_t state, state_nxt;
  logic [3:0] settle_cnt;
  vec_t       rom_data;
  logic       mismatch;
  logic       launch;

  alu_vec_rom u_rom (
    .addr(vec_idx),
    .data(rom_data)
  );

  assign mismatch = {alu.alu_f, alu.alu_ovf, alu.alu_take_branch} !=
                    {rom_data[F_LSB +: F_W], rom_data[OVF_LSB], rom_data[BR_LSB]};
  assign launch   = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (vec_idx == LAST_IDX || (mismatch && STOP_ON_FAIL)) state_nxt = ST_DONE;
        else                                                   state_nxt = ST_APPLY;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_CHECK);
    done = (state == ST_DONE);
    pass = done && (err_count == 5'd0);
  end

  // Operands only move on the APPLY edge so they stay stable through SETTLE and CHECK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu.alu_s        <= '0;
      alu.alu_a        <= '0;
      alu.alu_b        <= '0;
      settle_cnt       <= '0;
      vec_idx          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else if (launch) begin
      vec_idx          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      case (state)
        ST_APPLY: begin
          alu.alu_s  <= rom_data[S_LSB +: S_W];
          alu.alu_a  <= rom_data[A_LSB +: A_W];
          alu.alu_b  <= rom_data[B_LSB +: B_W];
          settle_cnt <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != 5'd31) err_count <= err_count + 5'd1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_idx;
            end
          end
          if (state_nxt == ST_APPLY) vec_idx <= vec_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
